cycle_sequencer: RTL and testbench
==================================

CYCLE_SEQUENCER -- requirements
Module: cycle_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 The `clk` port SHALL be an input, 1 bit wide: the single clock; all state changes on its rising edge.
REQ-003 The `reset` port SHALL be an input, 1 bit wide: synchronous, active-high reset.
REQ-004 The `op` port SHALL be an input, 4 bits wide: opcode field from the instruction register, valid from the DECODE state onward.
REQ-005 The `mem_ready` port SHALL be an input, 1 bit wide: memory completes the current request this cycle.
REQ-006 The `branch_taken` port SHALL be an input, 1 bit wide: ALU not-equal result, sampled in EXEC for branch opcodes.
REQ-007 The `mem_req` port SHALL be an output, 1 bit wide: memory request, held until `mem_ready`.
REQ-008 The `mem_sel` port SHALL be an output, 1 bit wide: 0 = instruction fetch address (PC), 1 = data address (ALU result).
REQ-009 The `mem_we` port SHALL be an output, 1 bit wide: memory write enable, valid only with `mem_req`.
REQ-010 The `ir_write` port SHALL be an output, 1 bit wide: load instruction register.
REQ-011 The `pc_write` port SHALL be an output, 1 bit wide: PC update strobe.
REQ-012 The `reg_write` port SHALL be an output, 1 bit wide: register file write strobe.
REQ-013 The `state` port SHALL be an output, 3 bits wide: current FSM state, for debug.
REQ-014 The `instr_done` port SHALL be an output, 1 bit wide: one-cycle pulse when an instruction retires.
REQ-015 The `retired` port SHALL be an output, 16 bits wide: count of retired instructions.
REQ-016 The `fault` port SHALL be an output, 1 bit wide: memory timeout, sticky until reset.

Function
REQ-017 The FSM SHALL have the states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4 and FAULT=7; codes 5 and 6 SHALL go to FETCH on the next edge.
REQ-018 In FETCH, the block SHALL assert `mem_req`=1 with `mem_sel`=0 and `mem_we`=0; on `mem_ready`=1 it SHALL assert `ir_write`=1 and `pc_write`=1 in that same cycle and go to DECODE; otherwise it SHALL stay in FETCH.
REQ-019 DECODE SHALL last exactly 1 cycle, SHALL capture `op` into an internal `op_q`, and SHALL then go to EXEC; later states SHALL use `op_q` only.
REQ-020 EXEC SHALL last exactly 1 cycle, with the next state chosen by `op_q`:
- add 0000, sub 0010, grt 0001, eq 0011, addi 1000, lui 0101, lli 1111 -> WB.
- lw 1001, sw 1010 -> MEM.
- jal 0110 -> `pc_write`=1, then WB.
- jalr 0100 -> `pc_write`=1, then FETCH; this retires.
- all other opcodes (branch) -> `pc_write`=`branch_taken`, then FETCH; this retires.
REQ-021 In MEM, the block SHALL assert `mem_req`=1 with `mem_sel`=1 and `mem_we`=(`op_q`==1010); on `mem_ready`, lw SHALL go to WB and sw SHALL go to FETCH and retire; otherwise it SHALL stay in MEM.
REQ-022 WB SHALL assert `reg_write`=1 for exactly 1 cycle, SHALL retire, and SHALL go to FETCH.
REQ-023 `mem_req`, `mem_sel` and `mem_we` SHALL be Moore outputs decoded from the state; `ir_write`, `pc_write` and `reg_write` SHALL be combinational from the state, `op_q`, `mem_ready` and `branch_taken`; each SHALL be 0 in every state and condition not listed above.
REQ-024 `instr_done` SHALL be combinational and high exactly in the cycle a retiring transition is taken; `retired` SHALL increment on that edge and wrap from 0xFFFF to 0x0000.
REQ-025 An 8-bit wait counter SHALL clear on entry to FETCH or MEM and on every `mem_ready`=1, and SHALL increment each cycle spent in FETCH or MEM with `mem_ready`=0.
REQ-026 When the wait counter is at 255 with `mem_ready`=0, the next state SHALL be FAULT; if `mem_ready`=1 at that count, the block SHALL complete normally instead.
REQ-027 In FAULT, `fault`=1 and all strobes, including `mem_req`, SHALL be 0; the block SHALL leave FAULT only on reset.
REQ-028 Cycle counts SHALL be as follows with `mem_ready` tied to 1:
- ALU ops, jal and lw: 4, 4 and 5 cycles respectively.
- jalr and branch: 3 cycles.
- sw: 4 cycles.

Reset
REQ-029 While `reset`=1 at a clock edge, the block SHALL load state=FETCH, `op_q`=0000, wait counter=0, `retired`=0 and `fault`=0, overriding every other transition, including mid-MEM and FAULT.
REQ-030 During reset cycles, all strobes SHALL be forced to 0, including `mem_req` and `instr_done`.
REQ-031 In the first cycle after reset is released, the block SHALL be in FETCH with `mem_req`=1 and `mem_sel`=0.

Verification
REQ-032 The bench SHALL cover an add: `mem_ready`=1, `op`=0000 -> states 0,1,2,4 -> `reg_write` high in cycle 4 only, `instr_done` pulse, `retired`=1.
REQ-033 The bench SHALL cover a lw with data wait: `op`=1001, `mem_ready` low 3 cycles in MEM -> MEM held 4 cycles with `mem_sel`=1 and `mem_we`=0, then WB; 8 cycles total.
REQ-034 The bench SHALL cover a branch: `op`=1011 with `branch_taken`=1 -> `pc_write` in FETCH and EXEC, no `reg_write`, 3 cycles; with `branch_taken`=0 -> `pc_write` only in FETCH.
REQ-035 The bench SHALL cover a timeout: `mem_ready` held 0 in FETCH -> FAULT after 256 cycles in FETCH, `fault`=1, `mem_req`=0; then `reset` pulse -> FETCH, `fault`=0.
REQ-036 The bench SHALL cover reset in MEM: `reset` asserted while a sw waits in MEM -> `mem_we` 0 that cycle, state=FETCH next, `retired`=0.
REQ-037 The bench SHALL cover counter wrap: preload 65535 retirements (or force) and retire one more -> `retired`=0x0000.

Source files
------------

// File: rtl/cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cycle_sequencer
// Description : Multi-cycle CPU control sequencer (fetch/decode/exec/mem/wb)
//               with memory-wait timeout, retire pulse and retire counter.
// Revision    : 1.0 - initial release
// ============================================================================
module cycle_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  op,
    input  logic        mem_ready,
    input  logic        branch_taken,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        mem_we,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [2:0]  state,
    output logic        instr_done,
    output logic [15:0] retired,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_RSV5   = 3'd5,
        S_RSV6   = 3'd6,
        S_FAULT  = 3'd7
    } state_t;

    localparam logic [3:0] c_OP_ADD  = 4'b0000;
    localparam logic [3:0] c_OP_GRT  = 4'b0001;
    localparam logic [3:0] c_OP_SUB  = 4'b0010;
    localparam logic [3:0] c_OP_EQ   = 4'b0011;
    localparam logic [3:0] c_OP_JALR = 4'b0100;
    localparam logic [3:0] c_OP_LUI  = 4'b0101;
    localparam logic [3:0] c_OP_JAL  = 4'b0110;
    localparam logic [3:0] c_OP_ADDI = 4'b1000;
    localparam logic [3:0] c_OP_LW   = 4'b1001;
    localparam logic [3:0] c_OP_SW   = 4'b1010;
    localparam logic [3:0] c_OP_LLI  = 4'b1111;
    localparam logic [7:0] c_WAIT_MAX = 8'hFF;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op_q;
    logic [7:0]  r_wait;
    logic [15:0] r_retired;
    logic        w_req;
    logic        w_sel;
    logic        w_we;
    logic        w_ir;
    logic        w_pc;
    logic        w_rw;
    logic        w_retire;
    logic        w_mem_wait;

    always_comb begin
        w_next   = r_state;
        w_req    = 1'b0;
        w_sel    = 1'b0;
        w_we     = 1'b0;
        w_ir     = 1'b0;
        w_pc     = 1'b0;
        w_rw     = 1'b0;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_ir   = 1'b1;
                    w_pc   = 1'b1;
                    w_next = S_DECODE;
                end else if (r_wait == c_WAIT_MAX) begin
                    w_next = S_FAULT;
                end
            end
            S_DECODE: w_next = S_EXEC;
            S_EXEC: begin
                case (r_op_q)
                    c_OP_ADD, c_OP_SUB, c_OP_GRT, c_OP_EQ,
                    c_OP_ADDI, c_OP_LUI, c_OP_LLI: w_next = S_WB;
                    c_OP_LW, c_OP_SW:              w_next = S_MEM;
                    c_OP_JAL: begin
                        w_pc   = 1'b1;
                        w_next = S_WB;
                    end
                    c_OP_JALR: begin
                        w_pc     = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    // every remaining opcode is a conditional branch
                    default: begin
                        w_pc     = branch_taken;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                w_req = 1'b1;
                w_sel = 1'b1;
                w_we  = (r_op_q == c_OP_SW);
                if (mem_ready) begin
                    if (r_op_q == c_OP_SW) begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next   = S_WB;
                    end
                end else if (r_wait == c_WAIT_MAX) begin
                    w_next = S_FAULT;
                end
            end
            S_WB: begin
                w_rw     = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
            end
            S_FAULT: w_next = S_FAULT;
            default: w_next = S_FETCH;
        endcase
    end

    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_op_q    <= 4'b0000;
            r_wait    <= 8'd0;
            r_retired <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == S_DECODE) begin
                r_op_q <= op;
            end
            // stall counter; any ready cycle or phase change restarts it
            r_wait <= w_mem_wait ? (r_wait + 8'd1) : 8'd0;
            if (w_retire) begin
                r_retired <= r_retired + 16'd1;
            end
        end
    end

    assign mem_req    = w_req    & ~reset;
    assign mem_sel    = w_sel    & ~reset;
    assign mem_we     = w_we     & ~reset;
    assign ir_write   = w_ir     & ~reset;
    assign pc_write   = w_pc     & ~reset;
    assign reg_write  = w_rw     & ~reset;
    assign instr_done = w_retire & ~reset;
    assign state      = r_state;
    assign retired    = r_retired;
    assign fault      = (r_state == S_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_cycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cycle_sequencer
// Description : Self-checking bench for cycle_sequencer: route-based model,
//               directed scenarios and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cycle_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  op = 4'd0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        mem_req, mem_sel, mem_we, ir_write, pc_write, reg_write;
    logic [2:0]  state;
    logic        instr_done;
    logic [15:0] retired;
    logic        fault;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cycle_sequencer dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_sel(mem_sel),
        .mem_we(mem_we), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .state(state), .instr_done(instr_done),
        .retired(retired), .fault(fault)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: each instruction is a route of phases; memory phases may stall.
    localparam int P_F = 0, P_D = 1, P_E = 2, P_M = 3, P_W = 4, P_FAULT = 7;
    int          m_route [5];
    int          m_idx, m_len, m_wait;
    logic [15:0] m_retired;
    logic        m_fault;
    logic        m_valid = 1'b0;
    logic [3:0]  m_opq;

    function automatic int exec_pc(input logic [3:0] o, input logic bt);
        case (o)
            4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd15, 4'd9, 4'd10: return 0;
            4'd4, 4'd6: return 1;
            default: return int'(bt);
        endcase
    endfunction

    int   ph;
    logic adv, tof;
    int   e_req, e_sel, e_we, e_ir, e_pc, e_rw, e_done;

    always @(negedge clk) begin
        ph = m_fault ? P_FAULT : m_route[m_idx];
        {adv, tof} = 2'b00;
        e_req = 0; e_sel = 0; e_we = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_done = 0;
        if (!m_fault) begin
            case (ph)
                P_F: begin
                    e_req = 1;
                    if (mem_ready) begin e_ir = 1; e_pc = 1; adv = 1; end
                    else if (m_wait == 255) tof = 1;
                end
                P_D: adv = 1;
                P_E: begin adv = 1; e_pc = exec_pc(m_opq, branch_taken); end
                P_M: begin
                    e_req = 1; e_sel = 1; e_we = (m_opq == 4'd10) ? 1 : 0;
                    if (mem_ready) adv = 1;
                    else if (m_wait == 255) tof = 1;
                end
                P_W: begin e_rw = 1; adv = 1; end
                default: ;
            endcase
        end
        if (adv && ph != P_D && (m_idx + 1 == m_len)) e_done = 1;
        if (reset) begin
            e_req = 0; e_sel = 0; e_we = 0; e_ir = 0; e_pc = 0; e_rw = 0; e_done = 0;
        end
        if (m_valid) begin
            chk("m_state", int'(state), ph);
            chk("m_mem_req", int'(mem_req), e_req);
            chk("m_mem_sel", int'(mem_sel), e_sel);
            chk("m_mem_we", int'(mem_we), e_we);
            chk("m_ir_write", int'(ir_write), e_ir);
            chk("m_pc_write", int'(pc_write), e_pc);
            chk("m_reg_write", int'(reg_write), e_rw);
            chk("m_instr_done", int'(instr_done), e_done);
            chk("m_retired", int'(retired), int'(m_retired));
            chk("m_fault", int'(fault), int'(m_fault));
        end
        if (reset) begin
            foreach (m_route[i]) m_route[i] = i;
            m_idx = 0; m_len = 3; m_wait = 0; m_retired = 16'd0;
            m_fault = 1'b0; m_opq = 4'd0; m_valid = 1'b1;
        end else if (m_valid && !m_fault) begin
            if (adv) begin
                if (ph == P_D) begin
                    m_opq = op;
                    case (op)
                        4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd8, 4'd15, 4'd6:
                            begin m_route[3] = P_W; m_len = 4; end
                        4'd9:  begin m_route[3] = P_M; m_route[4] = P_W; m_len = 5; end
                        4'd10: begin m_route[3] = P_M; m_len = 4; end
                        default: m_len = 3;
                    endcase
                end
                m_wait = 0;
                if (e_done) begin m_idx = 0; m_retired = m_retired + 16'd1; end
                else m_idx = m_idx + 1;
            end else if (tof) begin
                m_fault = 1'b1;
            end else if (ph == P_F || ph == P_M) begin
                m_wait = m_wait + 1;
            end
        end
    end

    task automatic drive(input logic r, input logic mr, input logic bt, input logic [3:0] o);
        @(posedge clk);
        #1;
        reset = r; mem_ready = mr; branch_taken = bt; op = o;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 1'b0, 4'd0);
    endtask

    initial begin
        int exp_add [4] = '{0, 1, 2, 4};
        int exp_lw  [8] = '{0, 1, 2, 3, 3, 3, 3, 4};
        logic lw_mr [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
        int cnt;
        logic hit;

        do_reset();
        do_reset();

        // add with memory always ready
        for (int c = 1; c <= 4; c++) begin
            drive(1'b0, 1'b1, 1'b0, 4'b0000);
            @(negedge clk);
            if (c == 1) begin
                chk("rst_mem_req", int'(mem_req), 1);
                chk("rst_mem_sel", int'(mem_sel), 0);
                chk("rst_retired", int'(retired), 0);
                chk("rst_fault", int'(fault), 0);
            end
            chk("add_state", int'(state), exp_add[c-1]);
            chk("add_reg_write", int'(reg_write), (c == 4) ? 1 : 0);
            chk("add_done", int'(instr_done), (c == 4) ? 1 : 0);
        end
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        chk("add_retired", int'(retired), 1);
        chk("add_next_state", int'(state), 0);

        // lw with three stall cycles in MEM
        do_reset();
        for (int c = 1; c <= 8; c++) begin
            drive(1'b0, lw_mr[c-1], 1'b0, 4'b1001);
            @(negedge clk);
            chk("lw_state", int'(state), exp_lw[c-1]);
            if (c >= 4 && c <= 7) begin
                chk("lw_mem_sel", int'(mem_sel), 1);
                chk("lw_mem_we", int'(mem_we), 0);
            end
            chk("lw_done", int'(instr_done), (c == 8) ? 1 : 0);
        end

        // branch taken then not taken
        do_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 1; c <= 3; c++) begin
                drive(1'b0, 1'b1, (k == 0), 4'b1011);
                @(negedge clk);
                chk("br_state", int'(state), c - 1);
                chk("br_pc_write", int'(pc_write), (c == 1 || (c == 3 && k == 0)) ? 1 : 0);
                chk("br_reg_write", int'(reg_write), 0);
                chk("br_done", int'(instr_done), (c == 3) ? 1 : 0);
            end
        end

        // fetch timeout
        do_reset();
        cnt = 0;
        hit = 1'b0;
        for (int n = 0; n < 300 && !hit; n++) begin
            drive(1'b0, 1'b0, 1'b0, 4'd0);
            @(negedge clk);
            if (state == 3'd7) hit = 1'b1;
            else if (state == 3'd0) cnt++;
        end
        chk("to_reached", int'(hit), 1);
        chk("to_fetch_cycles", cnt, 256);
        chk("to_fault", int'(fault), 1);
        chk("to_mem_req", int'(mem_req), 0);
        drive(1'b1, 1'b0, 1'b0, 4'd0);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        @(negedge clk);
        chk("to_rst_state", int'(state), 0);
        chk("to_rst_fault", int'(fault), 0);
        chk("to_rst_mem_req", int'(mem_req), 1);

        // finish a jalr, then reset a sw mid-MEM
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        @(negedge clk);
        chk("jalr_done", int'(instr_done), 1);
        drive(1'b0, 1'b1, 1'b0, 4'b1010);
        @(negedge clk);
        chk("sw_pre_retired", int'(retired), 1);
        drive(1'b0, 1'b1, 1'b0, 4'b1010);
        drive(1'b0, 1'b1, 1'b0, 4'b1010);
        drive(1'b0, 1'b0, 1'b0, 4'b1010);
        @(negedge clk);
        chk("sw_mem_state", int'(state), 3);
        chk("sw_mem_we", int'(mem_we), 1);
        drive(1'b1, 1'b0, 1'b0, 4'b1010);
        @(negedge clk);
        chk("sw_rst_mem_we", int'(mem_we), 0);
        chk("sw_rst_mem_req", int'(mem_req), 0);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        @(negedge clk);
        chk("sw_rst_state", int'(state), 0);
        chk("sw_rst_retired", int'(retired), 0);

        // retire counter wrap: preload 0xFFFF while a jalr is in flight
        #1;
        force dut.r_retired = 16'hFFFF;
        m_retired = 16'hFFFF;
        #1;
        release dut.r_retired;
        @(negedge clk);
        chk("wrap_pre", int'(retired), 32'hFFFF);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        drive(1'b0, 1'b1, 1'b0, 4'b0100);
        drive(1'b0, 1'b1, 1'b0, 4'b0000);
        @(negedge clk);
        chk("wrap_post", int'(retired), 0);

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 7),
                  1'($urandom), 4'($urandom));
        end
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
